// File: rtl/uart_ctrl.sv
// 8N1 UART with a one-byte receive holding register and a bus-bridge style
// strobe interface. TX and RX run independently from the same clock.
module uart_ctrl #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_we_n_i,
  input  logic       uart_re_n_i,
  input  logic [7:0] uart_tx_data_i,
  output logic       uart_tx_ready_o,
  output logic       uart_rx_ready_o,
  output logic [7:0] uart_rx_data_o,
  output logic       txd_o,
  input  logic       rxd_i
);

  localparam int DIV         = CLK_FREQ / BAUD;
  localparam int CW          = $clog2(DIV);
  localparam int SYNC_STAGES = 2;

  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  localparam logic [2:0] RX_IDLE      = 3'd0;
  localparam logic [2:0] RX_START     = 3'd1;
  localparam logic [2:0] RX_DATA      = 3'd2;
  localparam logic [2:0] RX_STOP      = 3'd3;
  localparam logic [2:0] RX_WAIT_HIGH = 3'd4;

  logic [1:0]    tx_state_reg;
  logic [CW-1:0] tx_cnt_reg;
  logic [2:0]    tx_bit_reg;
  logic [7:0]    tx_shift_reg;
  logic          txd_reg;

  logic [2:0]    rx_state_reg;
  logic [CW-1:0] rx_cnt_reg;
  logic [2:0]    rx_bit_reg;
  logic [7:0]    rx_shift_reg;
  logic [7:0]    rx_data_reg;
  logic          rx_ready_reg;

  logic          sync_reg [SYNC_STAGES];
  logic          rxd_s;

  // rxd_i is asynchronous; nothing downstream looks at it before the last stage.
  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    if (gi == 0) begin : g_first
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_reg[gi] <= 1'b1;
        else        sync_reg[gi] <= rxd_i;
      end
    end else begin : g_rest
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_reg[gi] <= 1'b1;
        else        sync_reg[gi] <= sync_reg[gi-1];
      end
    end
  end

  assign rxd_s = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_reg <= TX_IDLE;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      txd_reg      <= 1'b1;
    end else begin
      case (tx_state_reg)
        TX_IDLE: begin
          if (!uart_we_n_i) begin
            tx_shift_reg <= uart_tx_data_i;
            tx_cnt_reg   <= '0;
            txd_reg      <= 1'b0;
            tx_state_reg <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt_reg == BIT_LAST) begin
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            txd_reg      <= tx_shift_reg[0];
            tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
            tx_state_reg <= TX_DATA;
          end else begin
            tx_cnt_reg <= tx_cnt_reg + CW'(1);
          end
        end
        TX_DATA: begin
          if (tx_cnt_reg == BIT_LAST) begin
            tx_cnt_reg <= '0;
            if (tx_bit_reg == 3'd7) begin
              txd_reg      <= 1'b1;
              tx_state_reg <= TX_STOP;
            end else begin
              tx_bit_reg   <= tx_bit_reg + 3'd1;
              txd_reg      <= tx_shift_reg[0];
              tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
            end
          end else begin
            tx_cnt_reg <= tx_cnt_reg + CW'(1);
          end
        end
        TX_STOP: begin
          if (tx_cnt_reg == BIT_LAST) begin
            tx_cnt_reg   <= '0;
            tx_state_reg <= TX_IDLE;
          end else begin
            tx_cnt_reg <= tx_cnt_reg + CW'(1);
          end
        end
        default: tx_state_reg <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_reg <= RX_IDLE;
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
      rx_data_reg  <= '0;
      rx_ready_reg <= 1'b0;
    end else begin
      // A completing byte below overrides this clear in the same cycle.
      if (!uart_re_n_i && rx_ready_reg) rx_ready_reg <= 1'b0;
      case (rx_state_reg)
        RX_IDLE: begin
          if (!rxd_s) begin
            rx_cnt_reg   <= '0;
            rx_state_reg <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt_reg == HALF_LAST) begin
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_state_reg <= rxd_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt_reg == BIT_LAST) begin
            rx_cnt_reg   <= '0;
            rx_shift_reg <= {rxd_s, rx_shift_reg[7:1]};
            if (rx_bit_reg == 3'd7) rx_state_reg <= RX_STOP;
            else                    rx_bit_reg   <= rx_bit_reg + 3'd1;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt_reg == BIT_LAST) begin
            rx_cnt_reg <= '0;
            if (rxd_s) begin
              rx_data_reg  <= rx_shift_reg;
              rx_ready_reg <= 1'b1;
              rx_state_reg <= RX_IDLE;
            end else begin
              rx_state_reg <= RX_WAIT_HIGH;
            end
          end else begin
            rx_cnt_reg <= rx_cnt_reg + CW'(1);
          end
        end
        RX_WAIT_HIGH: begin
          if (rxd_s) rx_state_reg <= RX_IDLE;
        end
        default: rx_state_reg <= RX_IDLE;
      endcase
    end
  end

  assign uart_tx_ready_o = (tx_state_reg == TX_IDLE);
  assign txd_o           = txd_reg;
  assign uart_rx_ready_o = rx_ready_reg;
  assign uart_rx_data_o  = rx_data_reg;

endmodule

// File: tb/tb_uart_ctrl.sv
// Scoreboard bench for uart_ctrl at DIV=16: a background monitor checks every
// TX line cycle, RX bytes are checked when each driven frame completes.
module tb_uart_ctrl;
  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 100000;
  localparam int DIV      = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_we_n_i = 1'b1;
  logic       uart_re_n_i = 1'b1;
  logic [7:0] uart_tx_data_i = 8'h00;
  logic       rxd_i = 1'b1;
  logic       uart_tx_ready_o;
  logic       uart_rx_ready_o;
  logic [7:0] uart_rx_data_o;
  logic       txd_o;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic       mon_busy = 1'b0;

  uart_ctrl #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .uart_we_n_i    (uart_we_n_i),
    .uart_re_n_i    (uart_re_n_i),
    .uart_tx_data_i (uart_tx_data_i),
    .uart_tx_ready_o(uart_tx_ready_o),
    .uart_rx_ready_o(uart_rx_ready_o),
    .uart_rx_data_o (uart_rx_data_o),
    .txd_o          (txd_o),
    .rxd_i          (rxd_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // TX monitor: a falling txd_o starts a frame; compare all 160 line cycles.
  initial begin
    logic [9:0] frame;
    logic [3:0] bi;
    int         bad;
    int         low;
    logic       aborted;
    forever begin
      @(negedge clk);
      if (rst_n && txd_o == 1'b0) begin
        mon_busy = 1'b1;
        aborted  = 1'b0;
        bad      = 0;
        low      = 0;
        if (tx_q.size() == 0) begin
          chk("tx_unexpected_frame", 32'(tx_q.size()), 1);
          frame = 10'h200;
        end else begin
          frame = {1'b1, tx_q.pop_front(), 1'b0};
        end
        for (int k = 0; k < 10 * DIV; k++) begin
          if (k > 0) @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          bi = 4'(k / DIV);
          if (txd_o !== frame[bi]) bad++;
          if (!uart_tx_ready_o) low++;
        end
        if (!aborted) begin
          @(negedge clk);
          if (rst_n) begin
            chk("tx_line_bad_cycles", 32'(bad), 0);
            chk("tx_ready_low_cycles", 32'(low), 10 * DIV);
            chk("tx_ready_return", 32'(uart_tx_ready_o), 1);
            chk("tx_idle_level", 32'(txd_o), 1);
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  task automatic tx_write(input logic [7:0] d);
    int n = 0;
    while (!uart_tx_ready_o && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (!uart_tx_ready_o) begin
      chk("tx_write_timeout", 32'(uart_tx_ready_o), 1);
      return;
    end
    uart_tx_data_i = d;
    uart_we_n_i    = 1'b0;
    tx_q.push_back(d);
    @(posedge clk); #1;
    uart_we_n_i = 1'b1;
  endtask

  task automatic tx_write_ignored(input logic [7:0] d);
    chk("tx_busy_on_ignored_write", 32'(uart_tx_ready_o), 0);
    uart_tx_data_i = d;
    uart_we_n_i    = 1'b0;
    @(posedge clk); #1;
    uart_we_n_i = 1'b1;
  endtask

  task automatic wait_tx_idle();
    for (int n = 0; n < 2000; n++) begin
      if (uart_tx_ready_o && !mon_busy && tx_q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("tx_idle_reached", 32'(uart_tx_ready_o && !mon_busy), 1);
    chk("tx_q_drained", 32'(tx_q.size()), 0);
  endtask

  // Drives a full frame on rxd_i; re_at/rst_at are frame cycle indices (-1 = none).
  task automatic send_frame(input logic [7:0] d, input logic stop, input int re_at, input int rst_at);
    logic [9:0] frame;
    logic [3:0] bi;
    frame = {stop, d, 1'b0};
    if (stop && rst_at < 0) rx_q.push_back(d);
    for (int c = 0; c < 10 * DIV; c++) begin
      bi    = 4'(c / DIV);
      rxd_i = frame[bi];
      if (c == re_at)          uart_re_n_i = 1'b0;
      else if (c == re_at + 1) uart_re_n_i = 1'b1;
      if (c == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        return;
      end
      @(posedge clk); #1;
    end
    uart_re_n_i = 1'b1;
    rxd_i       = stop;
  endtask

  // An overrun leaves only the newest byte visible.
  task automatic rx_check(input string tag);
    logic [7:0] exp;
    chk({tag, "_ready"}, 32'(uart_rx_ready_o), 1);
    if (rx_q.size() == 0) begin
      chk({tag, "_queue"}, 32'(rx_q.size()), 1);
    end else begin
      while (rx_q.size() > 1) exp = rx_q.pop_front();
      exp = rx_q.pop_front();
      chk({tag, "_data"}, 32'(uart_rx_data_o), 32'(exp));
    end
  endtask

  task automatic rx_read(input logic [7:0] exp);
    uart_re_n_i = 1'b0;
    @(posedge clk); #1;
    uart_re_n_i = 1'b1;
    chk("rx_read_clears_ready", 32'(uart_rx_ready_o), 0);
    chk("rx_read_data_hold", 32'(uart_rx_data_o), 32'(exp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", 32'(txd_o), 1);
    chk("rst_tx_ready", 32'(uart_tx_ready_o), 1);
    chk("rst_rx_ready", 32'(uart_rx_ready_o), 0);
    chk("rst_rx_data", 32'(uart_rx_data_o), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    tx_write(8'hA5);
    wait_tx_idle();

    tx_write(8'h11);
    repeat (40) @(posedge clk);
    #1;
    tx_write_ignored(8'hEE);
    tx_write(8'h22);
    wait_tx_idle();

    tx_write(8'hC3);
    send_frame(8'h3C, 1'b1, -1, -1);
    rx_check("rx_3c");
    rx_read(8'h3C);
    rx_read(8'h3C);
    wait_tx_idle();

    rxd_i = 1'b0;
    repeat (5) @(posedge clk);
    #1 rxd_i = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    chk("rx_glitch_no_byte", 32'(uart_rx_ready_o), 0);
    chk("rx_glitch_data", 32'(uart_rx_data_o), 32'h3C);
    send_frame(8'h01, 1'b1, -1, -1);
    rx_check("rx_01");
    rx_read(8'h01);

    send_frame(8'hFF, 1'b0, -1, -1);
    repeat (40) @(posedge clk);
    #1;
    chk("rx_framing_no_byte", 32'(uart_rx_ready_o), 0);
    chk("rx_framing_data", 32'(uart_rx_data_o), 32'h01);
    rxd_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send_frame(8'h55, 1'b1, -1, -1);
    rx_check("rx_55");
    rx_read(8'h55);

    send_frame(8'h11, 1'b1, -1, -1);
    send_frame(8'h22, 1'b1, 154, -1);
    rx_check("rx_overrun");

    tx_write(8'h3C);
    send_frame(8'h96, 1'b1, -1, 88);
    chk("abort_txd", 32'(txd_o), 1);
    chk("abort_tx_ready", 32'(uart_tx_ready_o), 1);
    chk("abort_rx_ready", 32'(uart_rx_ready_o), 0);
    chk("abort_rx_data", 32'(uart_rx_data_o), 0);
    tx_q.delete();
    rxd_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    chk("abort_no_partial_byte", 32'(uart_rx_ready_o), 0);
    chk("abort_txd_idle", 32'(txd_o), 1);

    tx_write(8'h5A);
    send_frame(8'hC3, 1'b1, -1, -1);
    rx_check("rx_after_reset");
    wait_tx_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
